// File: rtl/buffer_drain_pkg.sv
// Shared definitions for buffer_drain: FSM state encoding and active-low seven-segment
// digit patterns (segment order gfedcba, bit 0 = a).
package buffer_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/buffer_drain_seg7_nibble.sv
// seg7_nibble: combinational 4-bit to active-low seven-segment decoder.
module seg7_nibble
  import buffer_drain_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_encode(i_nib);

endmodule

// File: rtl/buffer_drain.sv
// buffer_drain: pulls flushed words over valid/ready, holds each on a display register.
// Optional BUFFER_DRAIN_HEX_EN adds hex0..hex3 active-low seven-segment outputs.
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_word,
  output logic              out_valid,
  output logic [CNT_W-1:0]  drained_cnt,
  output logic              busy,
  output logic              done,
`ifdef BUFFER_DRAIN_HEX_EN
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both
  // high; in_ready is high only in WAIT, and in_valid/in_data are ignored otherwise.

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t              r_state, w_next_state;
  logic [HOLD_W-1:0]   r_hold, w_next_hold;
  logic                r_last, w_next_last;
  logic [DATA_W-1:0]   r_out_word, w_next_word;
  logic                r_out_valid, w_next_valid;
  logic [CNT_W-1:0]    r_cnt, w_next_cnt;
  logic                r_in_ready, r_busy, r_done;
  logic                w_accept;

  assign w_accept = (r_state == ST_WAIT) && in_valid && r_in_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_hold  = r_hold;
    w_next_last  = r_last;
    w_next_word  = r_out_word;
    w_next_valid = r_out_valid;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (flush_start) begin
          w_next_state = ST_WAIT;
          w_next_cnt   = '0;
          w_next_valid = 1'b0;
        end
      end
      ST_WAIT: begin
        if (w_accept) begin
          w_next_word  = in_data;
          w_next_valid = 1'b1;
          w_next_last  = in_last;
          w_next_hold  = HOLD_LOAD;
          w_next_state = ST_HOLD;
          if (r_cnt != {CNT_W{1'b1}}) w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_hold == '0) w_next_state = r_last ? ST_DONE : ST_WAIT;
        else              w_next_hold  = r_hold - 1'b1;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_last      <= 1'b0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_hold      <= w_next_hold;
      r_last      <= w_next_last;
      r_out_word  <= w_next_word;
      r_out_valid <= w_next_valid;
      r_cnt       <= w_next_cnt;
      r_in_ready  <= (w_next_state == ST_WAIT);
      r_busy      <= (w_next_state != ST_IDLE);
      r_done      <= (w_next_state == ST_DONE);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_word    = r_out_word;
  assign out_valid   = r_out_valid;
  assign drained_cnt = r_cnt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

`ifdef BUFFER_DRAIN_HEX_EN
  logic [6:0] w_seg [4];

  for (genvar g = 0; g < 4; g++) begin : g_seg
    seg7_nibble u_seg (
      .i_nib (r_out_word[4*g +: 4]),
      .o_seg (w_seg[g])
    );
  end

  assign hex0 = r_out_valid ? w_seg[0] : SEG_BLANK;
  assign hex1 = r_out_valid ? w_seg[1] : SEG_BLANK;
  assign hex2 = r_out_valid ? w_seg[2] : SEG_BLANK;
  assign hex3 = r_out_valid ? w_seg[3] : SEG_BLANK;
`endif

endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench for buffer_drain (HOLD_CYCLES=4): reset, single word, stream,
// flush during HOLD, counter saturation (second instance, CNT_W=2), optional HEX build.
module tb_buffer_drain;

  localparam int DATA_W = 16;
  localparam int HOLD   = 4;

  logic              clk;
  logic              rst_n;
  logic              flush_start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready, in_ready_s;
  logic [DATA_W-1:0] out_word, out_word_s;
  logic              out_valid, out_valid_s;
  logic [7:0]        drained_cnt;
  logic [1:0]        drained_cnt_s;
  logic              busy, busy_s, done, done_s;
  logic [1:0]        dbg_state, dbg_state_s;
`ifdef BUFFER_DRAIN_HEX_EN
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [6:0] hex0_s, hex1_s, hex2_s, hex3_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_q[$];

  buffer_drain #(.DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_start(flush_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
    .out_valid(out_valid), .drained_cnt(drained_cnt), .busy(busy), .done(done),
`ifdef BUFFER_DRAIN_HEX_EN
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
`endif
    .dbg_state(dbg_state)
  );

  buffer_drain #(.DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_start(flush_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready_s), .out_word(out_word_s),
    .out_valid(out_valid_s), .drained_cnt(drained_cnt_s), .busy(busy_s), .done(done_s),
`ifdef BUFFER_DRAIN_HEX_EN
    .hex0(hex0_s), .hex1(hex1_s), .hex2(hex2_s), .hex3(hex3_s),
`endif
    .dbg_state(dbg_state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // acceptance and done monitor (values sampled before the edge's updates)
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    if (rst_n && done) done_cnt++;
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_flush();
    @(negedge clk);
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] data, input logic last);
    int tries;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tries    = 0;
    while (!in_ready && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    check("accept_timeout", 32'(tries < 40), 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int tries;
    tries = 0;
    @(negedge clk);
    while (busy && tries < 60) begin
      @(negedge clk);
      tries++;
    end
    check("idle_timeout", 32'(tries < 60), 32'd1);
  endtask

  initial begin
    int zeros;
    int d0;
    int a0;
    rst_n = 1'b0;
    flush_start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef BUFFER_DRAIN_HEX_EN
    check("hex_blank", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
`endif

    // single word
    d0 = done_cnt;
    start_flush();
    check("wait_ready", 32'(in_ready), 32'd1);
    send_word(16'hBEEF, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("single_word", 32'(out_word), 32'hBEEF);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_cnt", 32'(drained_cnt), 32'd1);
    zeros = 0;
    for (int i = 0; i < HOLD; i++) begin
      if (i > 0) @(negedge clk);
      if (!in_ready && busy && !done) zeros++;
    end
    check("single_hold_cycles", 32'(zeros), 32'(HOLD));
    @(negedge clk);
    check("single_done", 32'(done), 32'd1);
    @(negedge clk);
    check("single_done_off", 32'(done), 32'd0);
    check("single_busy_off", 32'(busy), 32'd0);
    check("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("single_keep_word", 32'(out_word), 32'hBEEF);

    // stream of three with in_valid held high
    d0 = done_cnt;
    a0 = acc_q.size();
    start_flush();
    send_word(16'h1234, 1'b0);
    @(negedge clk);
    check("stream_hold_word", 32'(out_word), 32'h1234);
    send_word(16'h5678, 1'b0);
    send_word(16'h9ABC, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();
    check("stream_accepts", 32'(acc_q.size() - a0), 32'd3);
    if (acc_q.size() - a0 == 3) begin
      check("stream_gap1", 32'(acc_q[a0+1] - acc_q[a0]), 32'(HOLD + 1));
      check("stream_gap2", 32'(acc_q[a0+2] - acc_q[a0+1]), 32'(HOLD + 1));
    end
    check("stream_cnt", 32'(drained_cnt), 32'd3);
    check("stream_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("stream_word", 32'(out_word), 32'h9ABC);

    // flush_start during HOLD is ignored
    d0 = done_cnt;
    start_flush();
    send_word(16'h2222, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    check("restart_cnt", 32'(drained_cnt), 32'd1);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_state", 32'(dbg_state), 32'd2);
    send_word(16'h3333, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();
    check("restart_cnt_end", 32'(drained_cnt), 32'd2);
    check("restart_done_cnt", 32'(done_cnt - d0), 32'd1);

    // saturation: CNT_W=2 instance sticks at 3 while CNT_W=8 reaches 5
    start_flush();
    for (int i = 1; i <= 5; i++) send_word(16'(i), (i == 5));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();
    check("sat_cnt", 32'(drained_cnt_s), 32'd3);
    check("sat_ref_cnt", 32'(drained_cnt), 32'd5);

`ifdef BUFFER_DRAIN_HEX_EN
    start_flush();
    check("hex_blank_flush", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    send_word(16'h0A5F, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("hex3", 32'(hex3), 32'h40);
    check("hex2", 32'(hex2), 32'h08);
    check("hex1", 32'(hex1), 32'h12);
    check("hex0", 32'(hex0), 32'h0E);
    wait_idle();
`endif

    // async reset mid-HOLD, then in_valid without a flush is not accepted
    start_flush();
    send_word(16'h1111, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_word", 32'(out_word), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_cnt", 32'(drained_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd0);
    check("post_rst_cnt", 32'(drained_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
